// File: rtl/rand_pkg.sv
// Shared definitions for the random-request scheduler: FSM encoding and default sizes.
package rand_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 32;

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin pick: first set request at or above rr_ptr, with wrap.
module rr_arbiter_comb #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW:0]   sum;
  logic [IW-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      pos = sum[IW-1:0];
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/rand_req_scheduler.sv
// Shares one random-number generator among NREQ requesters: arbitrate, start,
// wait for done (with watchdog), and return the captured value to the winner.
module rand_req_scheduler
  import rand_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic             gen_start,
  input  logic             gen_done,
  input  logic [WIDTH-1:0] gen_data
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  // Handshake: req is a level held until the matching rsp_valid strobe; gnt
  // marks ownership from arbitration to the end of RESP; gen_start/gen_done
  // are single-cycle pulses and gen_data is only sampled with gen_done in WAIT.

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gidx;
  logic [CW-1:0]   wd_cnt;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  rr_arbiter_comb #(.NREQ(NREQ)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (arb_gnt),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      gidx      <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      gen_start <= 1'b0;
      busy      <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            gnt       <= arb_gnt;
            gidx      <= arb_idx;
            gen_start <= 1'b1;
            busy      <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          gen_start <= 1'b0;
          wd_cnt    <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (wd_cnt != '1) wd_cnt <= wd_cnt + CW'(1);
          // done is tested first so it wins a tie with the watchdog
          if (gen_done) begin
            rsp_data  <= gen_data;
            rsp_err   <= 1'b0;
            rsp_valid <= gnt;
            state     <= S_RESP;
          end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= gnt;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          rsp_valid <= '0;
          gnt       <= '0;
          busy      <= 1'b0;
          rr_ptr    <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_req_scheduler.sv
// Directed bench for rand_req_scheduler with a scripted generator (done/data driven per step).
module tb_rand_req_scheduler;
  import rand_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic       gen_start;
  logic       gen_done;
  logic [7:0] gen_data;

  int n_tests = 0;
  int n_fail  = 0;

  rand_req_scheduler #(.NREQ(4), .WIDTH(8), .TIMEOUT(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .gen_start (gen_start),
    .gen_done  (gen_done),
    .gen_data  (gen_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: d is the WAIT cycle (wd_cnt value) on which done is
  // driven, or -1 for a generator that never answers.
  task automatic do_txn(input string tag, input logic [3:0] r, input logic [3:0] r_wait,
                        input logic [3:0] r_after, input logic [3:0] exp_gnt, input int d,
                        input logic [7:0] data, input logic exp_err, input logic [7:0] exp_data,
                        input int exp_lat, input logic [1:0] exp_ptr);
    int cnt;
    int extra_starts;
    req      = r;
    gen_data = data;
    tick();
    chk({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
    chk({tag, " start"}, 32'(gen_start), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, " start_once"}, 32'(gen_start), 32'd0);
    req = r_wait;
    cnt = 0;
    extra_starts = 0;
    while (rsp_valid == 4'd0 && cnt < 40) begin
      gen_done = (cnt == d);
      tick();
      cnt++;
      if (gen_start) extra_starts++;
    end
    gen_done = 1'b0;
    chk({tag, " latency"}, 32'(cnt), 32'(exp_lat));
    chk({tag, " extra_starts"}, 32'(extra_starts), 32'd0);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(exp_gnt));
    chk({tag, " rsp_data"}, 32'(rsp_data), 32'(exp_data));
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, " gnt_held"}, 32'(gnt), 32'(exp_gnt));
    req = r_after;
    tick();
    chk({tag, " rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, " gnt_clr"}, 32'(gnt), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
    chk({tag, " state"}, 32'(dut.state), 32'(S_IDLE));
    chk({tag, " rr_ptr"}, 32'(dut.rr_ptr), 32'(exp_ptr));
    chk({tag, " data_hold"}, 32'(rsp_data), 32'(exp_data));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [3:0] fg;
    logic [1:0] fp;
    rst      = 1'b1;
    req      = 4'd0;
    gen_done = 1'b0;
    gen_data = 8'd0;
    tick();
    tick();
    chk("reset gnt", 32'(gnt), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_data", 32'(rsp_data), 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset gen_start", 32'(gen_start), 32'd0);
    chk("reset rr_ptr", 32'(dut.rr_ptr), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle no req", 32'(busy), 32'd0);

    // single request, done 6 cycles after start
    do_txn("single", 4'b0010, 4'b0010, 4'b0000, 4'b0010, 5, 8'hA5, 1'b0, 8'hA5, 6, 2'd2);

    // fairness from reset with every requester pending
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      fg = 4'b0001 << (i % 4);
      fp = 2'((i + 1) % 4);
      do_txn($sformatf("rr%0d", i), 4'b1111, 4'b1111, (i == 7) ? 4'b0000 : 4'b1111,
             fg, i, 8'h10 + 8'(i), 1'b0, 8'h10 + 8'(i), i + 1, fp);
    end

    // generator never answers: watchdog fires after 32 WAIT cycles
    do_txn("timeout", 4'b0001, 4'b0001, 4'b0000, 4'b0001, -1, 8'h99, 1'b1, 8'h00, 32, 2'd1);

    // done on the final watchdog cycle wins
    do_txn("tie", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 31, 8'h3C, 1'b0, 8'h3C, 32, 2'd1);

    // requester 2 drops req during WAIT but is still answered
    do_txn("drop", 4'b0100, 4'b0000, 4'b0000, 4'b0100, 3, 8'h77, 1'b0, 8'h77, 4, 2'd3);

    // spurious done while IDLE
    gen_done = 1'b1;
    gen_data = 8'hEE;
    tick();
    gen_done = 1'b0;
    chk("spurious state", 32'(dut.state), 32'(S_IDLE));
    chk("spurious busy", 32'(busy), 32'd0);
    chk("spurious rsp_valid", 32'(rsp_valid), 32'd0);
    chk("spurious rsp_data", 32'(rsp_data), 32'h77);
    tick();
    chk("spurious settle", 32'(busy), 32'd0);

    // asynchronous reset in the middle of WAIT
    req = 4'b0010;
    tick();
    chk("rstmid gnt", 32'(gnt), 32'b0010);
    tick();
    tick();
    tick();
    chk("rstmid in_wait", 32'(dut.state), 32'(S_WAIT));
    #2 rst = 1'b1;
    #1;
    chk("rstmid gnt_clr", 32'(gnt), 32'd0);
    chk("rstmid busy", 32'(busy), 32'd0);
    chk("rstmid gen_start", 32'(gen_start), 32'd0);
    chk("rstmid rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid rr_ptr", 32'(dut.rr_ptr), 32'd0);
    req = 4'b0000;
    tick();
    chk("rstmid no_rsp", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("rstmid after", 32'(rsp_valid), 32'd0);
    do_txn("post_rst", 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2, 8'h5A, 1'b0, 8'h5A, 3, 2'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
